// File: rtl/cmd_pkg.sv
// Shared ASCII constants and line-buffer state encoding for the command path.
// Consumed by the UART-to-command line assembler and its neighbours.
package cmd_pkg;

   localparam logic [7:0] ASC_A = 8'h61, ASC_B = 8'h62, ASC_C = 8'h63, ASC_D = 8'h64;
   localparam logic [7:0] ASC_E = 8'h65, ASC_F = 8'h66, ASC_G = 8'h67, ASC_H = 8'h68;
   localparam logic [7:0] ASC_I = 8'h69, ASC_J = 8'h6A, ASC_K = 8'h6B, ASC_L = 8'h6C;
   localparam logic [7:0] ASC_M = 8'h6D, ASC_N = 8'h6E, ASC_O = 8'h6F, ASC_P = 8'h70;
   localparam logic [7:0] ASC_Q = 8'h71, ASC_R = 8'h72, ASC_S = 8'h73, ASC_T = 8'h74;
   localparam logic [7:0] ASC_U = 8'h75, ASC_V = 8'h76, ASC_W = 8'h77, ASC_X = 8'h78;
   localparam logic [7:0] ASC_Y = 8'h79, ASC_Z = 8'h7A;

   localparam logic [7:0] ASC_ADD   = 8'h2B;
   localparam logic [7:0] ASC_SUB   = 8'h2D;
   localparam logic [7:0] ASC_MULT  = 8'h2A;
   localparam logic [7:0] ASC_DIV   = 8'h2F;
   localparam logic [7:0] ASC_SPACE = 8'h20;
   localparam logic [7:0] ASC_TILDE = 8'h7E;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_LF    = 8'h0A;
   localparam logic [7:0] ASC_BS    = 8'h08;
   localparam logic [7:0] ASC_DEL   = 8'h7F;
   localparam logic [7:0] ASC_UC_A  = 8'h41;
   localparam logic [7:0] ASC_UC_Z  = 8'h5A;

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_OVF     = 2'd1,
      S_COMMIT  = 2'd2
   } state_t;

endpackage

// File: rtl/command_line_buffer.sv
// Line editor: packs received ASCII bytes into a command word; commit pulses one cycle after enter.
// Backpressure: rx_ready drops for the commit cycle and while the one-deep echo slot is occupied.
module command_line_buffer
   import cmd_pkg::*;
#(
   parameter int unsigned  CMD_CHARS = 5,
   parameter logic [7:0]   PAD_CHAR  = ASC_SPACE,
   parameter bit           FOLD_CASE = 1'b1,
   parameter bit           ECHO_EN   = 1'b1,
   localparam int unsigned LW        = $clog2(CMD_CHARS + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic                   rx_ready,
   output logic [8*CMD_CHARS-1:0] cmd,
   output logic [LW-1:0]          cmd_len,
   output logic                   cmd_valid,
   output logic                   cmd_err,
   output logic [7:0]             echo_data,
   output logic                   echo_valid,
   input  logic                   echo_ready
);

   state_t                 state_q, state_d;
   logic [LW-1:0]          len_q, len_d;
   logic [7:0]             buf_q [CMD_CHARS];
   logic [7:0]             buf_d [CMD_CHARS];
   logic [8*CMD_CHARS-1:0] cmd_q, cmd_d;
   logic [LW-1:0]          cmd_len_q, cmd_len_d;
   logic                   cmd_valid_q, cmd_valid_d;
   logic                   cmd_err_q, cmd_err_d;
   logic                   echo_valid_q, echo_valid_d;
   logic [7:0]             echo_data_q, echo_data_d;

   logic [8*CMD_CHARS-1:0] line;
   logic                   take, full;
   logic                   is_print, is_bs, is_enter;
   logic [7:0]             ch;
   logic                   echo_now;
   logic [7:0]             echo_byte;

   // rx_ready is forced low while reset is asserted, not just after it.
   assign rx_ready = rst_n && (state_q != S_COMMIT) && !(ECHO_EN && echo_valid_q);
   assign take     = rx_valid && rx_ready;
   assign ch       = (FOLD_CASE && rx_data >= ASC_UC_A && rx_data <= ASC_UC_Z) ?
                     (rx_data | 8'h20) : rx_data;
   assign is_print = (ch >= ASC_SPACE) && (ch <= ASC_TILDE);
   assign is_bs    = (ch == ASC_BS) || (ch == ASC_DEL);
   assign is_enter = (ch == ASC_CR) || (ch == ASC_LF);
   assign full     = (len_q == LW'(CMD_CHARS));

   for (genvar g = 0; g < CMD_CHARS; g++) begin : g_line
      assign line[8*(CMD_CHARS-1-g) +: 8] = buf_q[g];
   end

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      buf_d        = buf_q;
      cmd_d        = cmd_q;
      cmd_len_d    = cmd_len_q;
      cmd_valid_d  = 1'b0;
      cmd_err_d    = 1'b0;
      echo_valid_d = echo_valid_q && !echo_ready;
      echo_data_d  = echo_data_q;
      echo_now     = 1'b0;
      echo_byte    = ch;

      case (state_q)
         S_COLLECT: begin
            if (take) begin
               if (is_print) begin
                  echo_now = 1'b1;
                  if (full) begin
                     state_d = S_OVF;
                  end else begin
                     for (int i = 0; i < CMD_CHARS; i++)
                        if (LW'(i) == len_q) buf_d[i] = ch;
                     len_d = len_q + 1'b1;
                  end
               end else if (is_bs && len_q != '0) begin
                  for (int i = 0; i < CMD_CHARS; i++)
                     if (LW'(i) == len_q - 1'b1) buf_d[i] = PAD_CHAR;
                  len_d     = len_q - 1'b1;
                  echo_now  = 1'b1;
                  echo_byte = ASC_BS;
               end else if (is_enter && len_q != '0) begin
                  // cmd is loaded on this edge so it is already stable when cmd_valid rises.
                  cmd_d       = line;
                  cmd_len_d   = len_q;
                  cmd_valid_d = 1'b1;
                  state_d     = S_COMMIT;
                  echo_now    = 1'b1;
                  echo_byte   = ASC_CR;
               end
            end
         end
         S_OVF: begin
            if (take) begin
               if (is_print) begin
                  echo_now = 1'b1;
               end else if (is_bs) begin
                  echo_now  = 1'b1;
                  echo_byte = ASC_BS;
               end else if (is_enter) begin
                  for (int i = 0; i < CMD_CHARS; i++) buf_d[i] = PAD_CHAR;
                  len_d     = '0;
                  cmd_err_d = 1'b1;
                  state_d   = S_COLLECT;
                  echo_now  = 1'b1;
                  echo_byte = ASC_CR;
               end
            end
         end
         S_COMMIT: begin
            for (int i = 0; i < CMD_CHARS; i++) buf_d[i] = PAD_CHAR;
            len_d   = '0;
            state_d = S_COLLECT;
         end
         default: state_d = S_COLLECT;
      endcase

      if (ECHO_EN && echo_now) begin
         echo_valid_d = 1'b1;
         echo_data_d  = echo_byte;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_COLLECT;
         len_q        <= '0;
         for (int i = 0; i < CMD_CHARS; i++) buf_q[i] <= PAD_CHAR;
         cmd_q        <= {CMD_CHARS{PAD_CHAR}};
         cmd_len_q    <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_err_q    <= 1'b0;
         echo_valid_q <= 1'b0;
         echo_data_q  <= 8'h00;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         buf_q        <= buf_d;
         cmd_q        <= cmd_d;
         cmd_len_q    <= cmd_len_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_err_q    <= cmd_err_d;
         echo_valid_q <= echo_valid_d;
         echo_data_q  <= echo_data_d;
      end
   end

   assign cmd        = cmd_q;
   assign cmd_len    = cmd_len_q;
   assign cmd_valid  = cmd_valid_q;
   assign cmd_err    = cmd_err_q;
   assign echo_valid = echo_valid_q;
   assign echo_data  = echo_data_q;

endmodule

// File: tb/tb_command_line_buffer.sv
// Bench for command_line_buffer: vector table, hand-written corner sequences and random bytes vs a queue model.
module tb_command_line_buffer;
   import cmd_pkg::*;

   localparam int N = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [39:0] cmd;
   logic [2:0]  cmd_len;
   logic        cmd_valid, cmd_err;
   logic [7:0]  echo_data;
   logic        echo_valid;
   logic        echo_ready = 1'b0;

   always #5 clk = ~clk;

   command_line_buffer dut (
      .clk(clk), .rst_n(rst_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .cmd(cmd), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_err(cmd_err),
      .echo_data(echo_data), .echo_valid(echo_valid), .echo_ready(echo_ready)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: the line is a queue of characters plus an overflow flag.
   byte unsigned mline[$];
   bit           movf = 1'b0;
   logic [39:0]  mcmd = {5{8'h20}};
   int           mlen = 0;
   byte unsigned exp_echo[$];
   byte unsigned got_echo[$];
   int exp_pulses = 0, got_pulses = 0, exp_errs = 0, got_errs = 0;
   bit echo_hold = 1'b0, echo_rand = 1'b0;

   function automatic logic [39:0] pack_line();
      logic [39:0] r;
      for (int i = 0; i < N; i++) r[8*(N-1-i) +: 8] = (i < mline.size()) ? mline[i] : 8'h20;
      return r;
   endfunction

   // Transmitter side: echo_ready is chosen at the negedge and held to the next posedge.
   always @(negedge clk) begin
      if (echo_hold)      echo_ready = 1'b0;
      else if (echo_rand) echo_ready = ($urandom_range(0, 2) != 0);
      else                echo_ready = 1'b1;
      if (rst_n && echo_valid && echo_ready) got_echo.push_back(echo_data);
      if (cmd_valid) got_pulses++;
      if (cmd_err) got_errs++;
      if (rst_n) chk("valid_err_exclusive", {63'd0, cmd_valid & cmd_err}, 64'd0);
   end

   // Called at a negedge; returns at the negedge one cycle after the byte is taken.
   task automatic send(input logic [7:0] b);
      int n = 0;
      logic [7:0] c;
      bit ecv = 1'b0, ece = 1'b0;
      rx_data = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rx_ready_wait", {63'd0, rx_ready}, 64'd1);
      if (!rx_ready) begin
         rx_valid = 1'b0;
         return;
      end
      c = (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
      if (c >= 8'h20 && c <= 8'h7E) begin
         exp_echo.push_back(c);
         if (!movf) begin
            if (mline.size() < N) mline.push_back(c);
            else movf = 1'b1;
         end
      end else if (c == 8'h08 || c == 8'h7F) begin
         if (movf) exp_echo.push_back(8'h08);
         else if (mline.size() > 0) begin
            void'(mline.pop_back());
            exp_echo.push_back(8'h08);
         end
      end else if (c == 8'h0D || c == 8'h0A) begin
         if (movf) begin
            movf = 1'b0;
            mline.delete();
            ece = 1'b1;
            exp_errs++;
            exp_echo.push_back(8'h0D);
         end else if (mline.size() > 0) begin
            mcmd = pack_line();
            mlen = mline.size();
            mline.delete();
            ecv = 1'b1;
            exp_pulses++;
            exp_echo.push_back(8'h0D);
         end
      end
      @(negedge clk);
      rx_valid = 1'b0;
      chk("cmd_valid_pulse", {63'd0, cmd_valid}, {63'd0, ecv});
      chk("cmd_err_pulse", {63'd0, cmd_err}, {63'd0, ece});
      if (ecv) begin
         chk("cmd_at_pulse", cmd, mcmd);
         chk("cmd_len_at_pulse", cmd_len, mlen);
      end
   endtask

   task automatic send_str(input string s);
      for (int k = 0; k < s.len(); k++) send(s[k]);
   endtask

   task automatic drain();
      echo_hold = 1'b0;
      echo_rand = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_rx_ready"}, {63'd0, rx_ready}, 64'd0);
      chk({tag, "_cmd"}, cmd, 40'h2020202020);
      chk({tag, "_cmd_len"}, cmd_len, 64'd0);
      chk({tag, "_cmd_valid"}, {63'd0, cmd_valid}, 64'd0);
      chk({tag, "_cmd_err"}, {63'd0, cmd_err}, 64'd0);
      chk({tag, "_echo_valid"}, {63'd0, echo_valid}, 64'd0);
      chk({tag, "_echo_data"}, echo_data, 64'd0);
   endtask

   typedef struct {
      string       s;
      logic [39:0] ecmd;
      logic [2:0]  elen;
      int          epulse;
      int          eerr;
   } vec_t;

   vec_t tbl[9];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p0, e0;
      int r;
      logic [7:0] b;

      tbl[0] = '{"reset\015",            40'h7265736574, 3'd5, 1, 0};
      tbl[1] = '{"ab\015\012",           40'h6162202020, 3'd2, 1, 0};
      tbl[2] = '{"smx\010ile\015",       40'h736d696c65, 3'd5, 1, 0};
      tbl[3] = '{"lazerz\015",           40'h736d696c65, 3'd5, 0, 1};
      tbl[4] = '{"\010go+1\177\177\015", 40'h676f202020, 3'd2, 1, 0};
      tbl[5] = '{"\001x\033\015",        40'h7820202020, 3'd1, 1, 0};
      tbl[6] = '{"AbC/\015\015",         40'h6162632f20, 3'd4, 1, 0};
      tbl[7] = '{"abcdef\010\015",       40'h6162632f20, 3'd4, 0, 1};
      tbl[8] = '{"\015",                 40'h6162632f20, 3'd4, 0, 0};

      #2 rst_n = 1'b0;
      @(negedge clk);
      check_reset_values("reset0");
      rst_n = 1'b1;
      @(negedge clk);
      chk("rx_ready_after_reset", {63'd0, rx_ready}, 64'd1);

      for (int t = 0; t < 9; t++) begin
         p0 = got_pulses;
         e0 = got_errs;
         send_str(tbl[t].s);
         drain();
         chk($sformatf("vec%0d_cmd", t), cmd, tbl[t].ecmd);
         chk($sformatf("vec%0d_cmd_len", t), cmd_len, tbl[t].elen);
         chk($sformatf("vec%0d_pulses", t), got_pulses - p0, tbl[t].epulse);
         chk($sformatf("vec%0d_errs", t), got_errs - e0, tbl[t].eerr);
      end

      // Echo slot held full: rx must stall until the transmitter takes the byte.
      echo_hold = 1'b1;
      @(negedge clk);
      send(8'h53);
      chk("hold_echo_valid", {63'd0, echo_valid}, 64'd1);
      chk("hold_echo_data", echo_data, 64'h73);
      chk("hold_rx_ready", {63'd0, rx_ready}, 64'd0);
      repeat (3) @(negedge clk);
      chk("hold_rx_ready_later", {63'd0, rx_ready}, 64'd0);
      chk("hold_echo_still_valid", {63'd0, echo_valid}, 64'd1);
      echo_hold = 1'b0;
      send_str("MILE\015");
      drain();
      chk("fold_cmd", cmd, 40'h736d696c65);
      chk("fold_cmd_len", cmd_len, 64'd5);

      // Reset in the middle of a line discards it.
      send_str("03+");
      drain();
      rst_n = 1'b0;
      mline.delete();
      movf = 1'b0;
      mcmd = {5{8'h20}};
      mlen = 0;
      @(negedge clk);
      check_reset_values("reset1");
      rst_n = 1'b1;
      @(negedge clk);
      send_str("05\015");
      drain();
      chk("after_reset_cmd", cmd, 40'h3035202020);
      chk("after_reset_cmd_len", cmd_len, 64'd2);

      // Random bytes, random gaps and random echo_ready.
      echo_rand = 1'b1;
      for (int k = 0; k < 400; k++) begin
         r = $urandom_range(0, 99);
         if (r < 45)      b = 8'h61 + 8'($urandom_range(0, 25));
         else if (r < 55) b = 8'h41 + 8'($urandom_range(0, 25));
         else if (r < 63) b = 8'h20 + 8'($urandom_range(0, 31));
         else if (r < 76) b = ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F;
         else if (r < 92) b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
         else             b = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(128, 255));
         send(b);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
      chk("final_cmd", cmd, mcmd);
      chk("final_cmd_len", cmd_len, mlen);
      chk("total_pulses", got_pulses, exp_pulses);
      chk("total_errs", got_errs, exp_errs);
      chk("echo_count", got_echo.size(), exp_echo.size());
      for (int i = 0; i < exp_echo.size() && i < got_echo.size(); i++)
         chk($sformatf("echo%0d", i), got_echo[i], exp_echo[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
